mux_2_1_tdm_sequencer: RTL and testbench

- Upstream driver for the 2:1 MUX. Accepts two parallel words per frame over a valid/ready handshake and drives the MUX's two data lines, select line and enable line.
- Serializes both words LSB-first and interleaves them bit-by-bit onto the single MUX output, stream 0 then stream 1.
- While idle, holds enable low so the MUX output floats (Z).

---
 rtl/mux_2_1_tdm_sequencer.sv | 154 +++++++++++++++
 tb/tb_mux_2_1_tdm_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2_1_tdm_sequencer.sv
// Drives a 2:1 MUX from two parallel words: both streams go out LSB-first, interleaved stream 0 then stream 1.
// Optional trailing even-parity slot pair is enabled by defining MUX_2_1_TDM_PARITY_EN.
module mux_2_1_tdm_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clock_In,
    input  logic                   Reset_In,
    input  logic                   Load_Valid_In,
    output logic                   Load_Ready_Out,
    input  logic [DATA_WIDTH-1:0]  Word_0_In,
    input  logic [DATA_WIDTH-1:0]  Word_1_In,
    output logic                   Data_0_Out,
    output logic                   Data_1_Out,
    output logic                   Select_Out,
    output logic                   Enable_Out,
    output logic                   Busy_Out,
    output logic                   Frame_Done_Out,
    output logic [COUNT_WIDTH-1:0] Frame_Count_Out
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

`ifdef MUX_2_1_TDM_PARITY_EN
    typedef enum logic [2:0] {IDLE, SLOT0, SLOT1, DONE, PAR0, PAR1} state_t;
`else
    typedef enum logic [1:0] {IDLE, SLOT0, SLOT1, DONE} state_t;
`endif

    state_t                 state_reg;
    logic [DATA_WIDTH-1:0]  sh0_reg;
    logic [DATA_WIDTH-1:0]  sh1_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic                   ready_reg;
    logic                   data0_reg;
    logic                   data1_reg;
    logic                   sel_reg;
    logic                   en_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
`ifdef MUX_2_1_TDM_PARITY_EN
    logic                   par0_reg;
    logic                   par1_reg;
`endif

    // Outputs are registered one state ahead: each state's values are loaded on the edge that enters it.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_reg <= IDLE;
            sh0_reg   <= '0;
            sh1_reg   <= '0;
            idx_reg   <= '0;
            ready_reg <= 1'b1;
            data0_reg <= 1'b0;
            data1_reg <= 1'b0;
            sel_reg   <= 1'b0;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            count_reg <= '0;
`ifdef MUX_2_1_TDM_PARITY_EN
            par0_reg  <= 1'b0;
            par1_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Load_Valid_In && ready_reg) begin
                        sh0_reg   <= Word_0_In;
                        sh1_reg   <= Word_1_In;
                        idx_reg   <= '0;
                        data0_reg <= Word_0_In[0];
                        data1_reg <= Word_1_In[0];
                        sel_reg   <= 1'b0;
                        en_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b0;
`ifdef MUX_2_1_TDM_PARITY_EN
                        par0_reg  <= ^Word_0_In;
                        par1_reg  <= ^Word_1_In;
`endif
                        state_reg <= SLOT0;
                    end
                end
                SLOT0: begin
                    sel_reg   <= 1'b1;
                    state_reg <= SLOT1;
                end
                SLOT1: begin
                    sh0_reg <= sh0_reg >> 1;
                    sh1_reg <= sh1_reg >> 1;
                    idx_reg <= idx_reg + 1'b1;
                    sel_reg <= 1'b0;
                    if (idx_reg == LAST_IDX) begin
`ifdef MUX_2_1_TDM_PARITY_EN
                        data0_reg <= par0_reg;
                        data1_reg <= par1_reg;
                        state_reg <= PAR0;
`else
                        data0_reg <= 1'b0;
                        data1_reg <= 1'b0;
                        en_reg    <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        count_reg <= count_reg + 1'b1;
                        state_reg <= DONE;
`endif
                    end else begin
                        // Next bit sits at [1] because the shift lands on this same edge.
                        data0_reg <= sh0_reg[1];
                        data1_reg <= sh1_reg[1];
                        state_reg <= SLOT0;
                    end
                end
`ifdef MUX_2_1_TDM_PARITY_EN
                PAR0: begin
                    sel_reg   <= 1'b1;
                    state_reg <= PAR1;
                end
                PAR1: begin
                    sel_reg   <= 1'b0;
                    data0_reg <= 1'b0;
                    data1_reg <= 1'b0;
                    en_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    count_reg <= count_reg + 1'b1;
                    state_reg <= DONE;
                end
`endif
                DONE: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Load_Ready_Out  = ready_reg;
    assign Data_0_Out      = data0_reg;
    assign Data_1_Out      = data1_reg;
    assign Select_Out      = sel_reg;
    assign Enable_Out      = en_reg;
    assign Busy_Out        = busy_reg;
    assign Frame_Done_Out  = done_reg;
    assign Frame_Count_Out = count_reg;

endmodule

// File: tb/tb_mux_2_1_tdm_sequencer.sv
// Randomized self-checking bench for mux_2_1_tdm_sequencer against a frame-timing model.
// Honours MUX_2_1_TDM_PARITY_EN for frame length and trailing parity bits.
module tb_mux_2_1_tdm_sequencer;

    localparam int DW = 8;
    localparam int CW = 2;
`ifdef MUX_2_1_TDM_PARITY_EN
    localparam int E = 2 * DW + 2;
`else
    localparam int E = 2 * DW;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Reset_In = 1'b1;
    logic          Load_Valid_In = 1'b0;
    logic [DW-1:0] Word_0_In = '0;
    logic [DW-1:0] Word_1_In = '0;
    logic          Load_Ready_Out, Data_0_Out, Data_1_Out, Select_Out, Enable_Out;
    logic          Busy_Out, Frame_Done_Out;
    logic [CW-1:0] Frame_Count_Out;

    mux_2_1_tdm_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .Clock_In        (clk),
        .Reset_In        (Reset_In),
        .Load_Valid_In   (Load_Valid_In),
        .Load_Ready_Out  (Load_Ready_Out),
        .Word_0_In       (Word_0_In),
        .Word_1_In       (Word_1_In),
        .Data_0_Out      (Data_0_Out),
        .Data_1_Out      (Data_1_Out),
        .Select_Out      (Select_Out),
        .Enable_Out      (Enable_Out),
        .Busy_Out        (Busy_Out),
        .Frame_Done_Out  (Frame_Done_Out),
        .Frame_Count_Out (Frame_Count_Out)
    );

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    // Per-sample record; sample k is taken on the negedge after edge k-1, so sample r is cycle r of a frame.
    logic [6:0]    s_vec [0:255];
    logic [CW-1:0] s_cnt [0:255];
    logic          s_mux [0:255];
    logic [DW-1:0] s_w0  [0:255];
    logic [DW-1:0] s_w1  [0:255];

    localparam logic [6:0] IDLE_VEC = 7'b0000001;

    function automatic logic [6:0] obs_now();
        return {Enable_Out, Select_Out, Data_0_Out, Data_1_Out, Busy_Out, Frame_Done_Out, Load_Ready_Out};
    endfunction

    // Expected {enable, select, data0, data1, busy, done, ready} at cycle r of a frame holding w0/w1.
    function automatic logic [6:0] model_vec(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input int r);
        logic en, sel, d0, d1;
        int   slot, bitn;
        en = (r >= 1) && (r <= E);
        sel = 1'b0; d0 = 1'b0; d1 = 1'b0;
        if (en) begin
            slot = r - 1;
            bitn = slot / 2;
            sel  = slot[0];
            if (bitn < DW) begin
                d0 = w0[bitn];
                d1 = w1[bitn];
            end else begin
                d0 = ^w0;
                d1 = ^w1;
            end
        end
        return {en, sel, d0, d1, en, r == E + 1, (r <= 0) || (r >= E + 2)};
    endfunction

    // Drives valid (and optionally fresh words every cycle) and records outputs; no checking here.
    task automatic capture(input int ncyc, input int valid_until, input bit scramble);
        for (int k = 0; k <= ncyc; k++) begin
            s_vec[k] = obs_now();
            s_cnt[k] = Frame_Count_Out;
            s_mux[k] = Select_Out ? Data_1_Out : Data_0_Out;
            if (k == ncyc) break;
            Load_Valid_In = (k < valid_until);
            if (scramble) begin
                Word_0_In = DW'($urandom);
                Word_1_In = DW'($urandom);
            end
            s_w0[k] = Word_0_In;
            s_w1[k] = Word_1_In;
            @(posedge clk);
            @(negedge clk);
        end
        Load_Valid_In = 1'b0;
    endtask

    task automatic test_reset();
        Reset_In = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs_now() !== IDLE_VEC || Frame_Count_Out !== '0) begin
                errors++;
                $display("FAIL reset cyc%0d outs=%b cnt=%0d want outs=%b cnt=0", c, obs_now(), Frame_Count_Out, IDLE_VEC);
            end
        end
        Reset_In = 1'b0;
        exp_count = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_now() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_release outs=%b want %b", obs_now(), IDLE_VEC);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] w0, w1;
        logic          stream_q[$];
        w0 = 8'hA5;
        w1 = 8'h3C;
        for (int i = 0; i < DW; i++) begin
            stream_q.push_back(w0[i]);
            stream_q.push_back(w1[i]);
        end
`ifdef MUX_2_1_TDM_PARITY_EN
        stream_q.push_back(^w0);
        stream_q.push_back(^w1);
`endif
        Word_0_In = w0;
        Word_1_In = w1;
        capture(E + 2, 1, 1'b0);
        exp_count = (exp_count + 1) % (1 << CW);
        for (int j = 0; j <= E + 2; j++) begin
            checks++;
            if (s_vec[j] !== model_vec(w0, w1, j)) begin
                errors++;
                $display("FAIL basic_outs cyc%0d got=%b want=%b", j, s_vec[j], model_vec(w0, w1, j));
            end
            if (j >= 1 && j <= E) begin
                checks++;
                if (s_mux[j] !== stream_q[j-1]) begin
                    errors++;
                    $display("FAIL basic_mux cyc%0d got=%b want=%b", j, s_mux[j], stream_q[j-1]);
                end
            end
        end
        checks++;
        if (s_cnt[E+1] !== CW'(exp_count)) begin
            errors++;
            $display("FAIL basic_count got=%0d want=%0d", s_cnt[E+1], exp_count);
        end
        $display("basic frame w0=%h w1=%h count=%0d", w0, w1, s_cnt[E+1]);
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] w0, w1;
        w0 = DW'($urandom);
        w1 = DW'($urandom);
        Word_0_In = w0;
        Word_1_In = w1;
        Load_Valid_In = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Load_Valid_In = 1'b0;
        for (int c = 1; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (obs_now() !== model_vec(w0, w1, 5)) begin
            errors++;
            $display("FAIL midreset_cyc5 got=%b want=%b", obs_now(), model_vec(w0, w1, 5));
        end
        Reset_In = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Reset_In = 1'b0;
        exp_count = 0;
        checks++;
        if (obs_now() !== IDLE_VEC || Frame_Count_Out !== '0) begin
            errors++;
            $display("FAIL midreset_abort outs=%b cnt=%0d want outs=%b cnt=0", obs_now(), Frame_Count_Out, IDLE_VEC);
        end
        for (int c = 0; c < E + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs_now() !== IDLE_VEC || Frame_Count_Out !== '0) begin
                errors++;
                $display("FAIL midreset_quiet cyc%0d outs=%b cnt=%0d", c, obs_now(), Frame_Count_Out);
            end
        end
        $display("mid-frame reset abandoned frame w0=%h w1=%h", w0, w1);
    endtask

    task automatic test_reset_handshake();
        Word_0_In = DW'($urandom);
        Word_1_In = DW'($urandom);
        Load_Valid_In = 1'b1;
        Reset_In = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Load_Valid_In = 1'b0;
        Reset_In = 1'b0;
        checks++;
        if (obs_now() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_vs_load got=%b want=%b", obs_now(), IDLE_VEC);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_now() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_vs_load_after got=%b want=%b", obs_now(), IDLE_VEC);
        end
        $display("reset coincident with load: frame dropped");
    endtask

    task automatic test_wrap();
        int wrap_tbl [5] = '{1, 2, 3, 0, 1};
        for (int f = 0; f < 5; f++) begin
            Word_0_In = DW'($urandom);
            Word_1_In = DW'($urandom);
            capture(E + 2, 1, 1'b0);
            checks++;
            if (s_cnt[E+1] !== CW'(wrap_tbl[f]) || s_cnt[E] !== CW'(wrap_tbl[(f + 4) % 5] * (f > 0 ? 1 : 0))) begin
                errors++;
                $display("FAIL wrap_count frame%0d before=%0d after=%0d want after=%0d", f, s_cnt[E], s_cnt[E+1], wrap_tbl[f]);
            end
            $display("wrap frame %0d count=%0d", f, s_cnt[E+1]);
        end
        exp_count = 1;
    endtask

    task automatic test_random_frames();
        logic [DW-1:0] w0, w1;
        for (int f = 0; f < 4; f++) begin
            w0 = DW'($urandom);
            w1 = DW'($urandom);
            Word_0_In = w0;
            Word_1_In = w1;
            capture(E + 2, 1, 1'b0);
            exp_count = (exp_count + 1) % (1 << CW);
            for (int j = 0; j <= E + 2; j++) begin
                checks++;
                if (s_vec[j] !== model_vec(w0, w1, j)) begin
                    errors++;
                    $display("FAIL random_outs frame%0d cyc%0d got=%b want=%b", f, j, s_vec[j], model_vec(w0, w1, j));
                end
            end
            checks++;
            if (s_cnt[E+1] !== CW'(exp_count)) begin
                errors++;
                $display("FAIL random_count frame%0d got=%0d want=%0d", f, s_cnt[E+1], exp_count);
            end
            $display("random frame %0d w0=%h w1=%h", f, w0, w1);
        end
    endtask

    // Valid held high with words changing every cycle: only the accepting-edge words matter.
    task automatic test_back_to_back();
        int            r;
        logic [DW-1:0] a0, a1, b0, b1;
        logic [6:0]    want;
        capture(2 * E + 4, E + 3, 1'b1);
        a0 = s_w0[0];     a1 = s_w1[0];
        b0 = s_w0[E + 2]; b1 = s_w1[E + 2];
        for (int j = 0; j <= 2 * E + 4; j++) begin
            if (j <= E + 2) begin
                r = j;
                want = model_vec(a0, a1, r);
            end else begin
                r = j - (E + 2);
                want = model_vec(b0, b1, r);
            end
            checks++;
            if (s_vec[j] !== want) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got=%b want=%b", j, s_vec[j], want);
            end
        end
        exp_count = (exp_count + 1) % (1 << CW);
        checks++;
        if (s_cnt[E+1] !== CW'(exp_count)) begin
            errors++;
            $display("FAIL b2b_count1 got=%0d want=%0d", s_cnt[E+1], exp_count);
        end
        exp_count = (exp_count + 1) % (1 << CW);
        checks++;
        if (s_cnt[2*E+3] !== CW'(exp_count)) begin
            errors++;
            $display("FAIL b2b_count2 got=%0d want=%0d", s_cnt[2*E+3], exp_count);
        end
        $display("back-to-back frames a=%h/%h b=%h/%h", a0, a1, b0, b1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_mid_reset();
        test_reset_handshake();
        test_wrap();
        test_random_frames();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
